// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared state encoding and phase codes for the layer scheduler
package sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LD_ISS  = 4'd1,
        S_LD_WAIT = 4'd2,
        S_CP_ISS  = 4'd3,
        S_CP_WAIT = 4'd4,
        S_WB_ISS  = 4'd5,
        S_WB_WAIT = 4'd6,
        S_FINISH  = 4'd7,
        S_ERROR   = 4'd8
    } state_t;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH_LOAD = 2'd1;
    localparam logic [1:0] PH_COMP = 2'd2;
    localparam logic [1:0] PH_WB   = 2'd3;

    // Issue states restart the watchdog for the phase that follows them
    function automatic logic is_issue(input state_t s);
        return (s == S_LD_ISS) || (s == S_CP_ISS) || (s == S_WB_ISS);
    endfunction

endpackage

// File: rtl/phase_watchdog.sv
// rtl/phase_watchdog.sv - per-phase wait-cycle counter that flags a stuck engine
module phase_watchdog #(
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // expired marks the wait cycle that would bring the count to TIMEOUT_CYCLES,
    // so the FSM leaves on the same edge the count would reach the limit
    localparam logic [TIMEOUT_W-1:0] LAST =
        TIMEOUT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [TIMEOUT_W-1:0] count;

    // Count wait cycles without a done; saturate so a disabled watchdog never wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LAST);

endmodule

// File: rtl/layer_scheduler.sv
// rtl/layer_scheduler.sv - per-layer load/compute/writeback sequencer with watchdog
module layer_scheduler
    import sched_pkg::*;
#(
    parameter int LAYER_W        = 8,
    parameter int TIMEOUT_W      = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               clear_err,
    input  logic [LAYER_W-1:0] num_layers,
    output logic               load_start,
    input  logic               load_done,
    output logic               input_compute_start,
    input  logic               input_compute_done,
    output logic               writeback_start,
    input  logic               writeback_done,
    output logic               busy,
    output logic [LAYER_W-1:0] layer_idx,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_phase
);

    state_t             state;
    logic [LAYER_W-1:0] n_latched;
    logic               phase_done;
    logic               in_wait;
    logic               wd_clear;
    logic               wd_enable;
    logic               wd_expired;

    // Select the done input that belongs to the current wait state; others are ignored
    always_comb begin
        phase_done = 1'b0;
        in_wait    = 1'b0;
        case (state)
            S_LD_WAIT: begin in_wait = 1'b1; phase_done = load_done;          end
            S_CP_WAIT: begin in_wait = 1'b1; phase_done = input_compute_done; end
            S_WB_WAIT: begin in_wait = 1'b1; phase_done = writeback_done;     end
            default:   ;
        endcase
        wd_clear  = is_issue(state);
        wd_enable = in_wait && !phase_done && !abort;
    end

    phase_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Sequencer: state, layer counter and all registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= S_IDLE;
            n_latched           <= '0;
            layer_idx           <= '0;
            load_start          <= 1'b0;
            input_compute_start <= 1'b0;
            writeback_start     <= 1'b0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
            err_phase           <= PH_NONE;
        end else begin
            load_start          <= 1'b0;
            input_compute_start <= 1'b0;
            writeback_start     <= 1'b0;
            done                <= 1'b0;
            if (abort && busy) begin
                state <= S_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            n_latched <= num_layers;
                            busy      <= 1'b1;
                            if (num_layers == '0) begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end else begin
                                layer_idx  <= '0;
                                state      <= S_LD_ISS;
                                load_start <= 1'b1;
                            end
                        end
                    end
                    S_LD_ISS: state <= S_LD_WAIT;
                    S_CP_ISS: state <= S_CP_WAIT;
                    S_WB_ISS: state <= S_WB_WAIT;
                    S_LD_WAIT: begin
                        if (phase_done) begin
                            state               <= S_CP_ISS;
                            input_compute_start <= 1'b1;
                        end else if (wd_expired) begin
                            state     <= S_ERROR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_phase <= PH_LOAD;
                        end
                    end
                    S_CP_WAIT: begin
                        if (phase_done) begin
                            state           <= S_WB_ISS;
                            writeback_start <= 1'b1;
                        end else if (wd_expired) begin
                            state     <= S_ERROR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_phase <= PH_COMP;
                        end
                    end
                    S_WB_WAIT: begin
                        if (phase_done) begin
                            if (layer_idx == n_latched - LAYER_W'(1)) begin
                                state <= S_FINISH;
                                done  <= 1'b1;
                            end else begin
                                layer_idx  <= layer_idx + 1'b1;
                                state      <= S_LD_ISS;
                                load_start <= 1'b1;
                            end
                        end else if (wd_expired) begin
                            state     <= S_ERROR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_phase <= PH_WB;
                        end
                    end
                    S_FINISH: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    S_ERROR: begin
                        if (clear_err) begin
                            state     <= S_IDLE;
                            error     <= 1'b0;
                            err_phase <= PH_NONE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_layer_scheduler.sv
// tb/tb_layer_scheduler.sv - directed self-checking bench for layer_scheduler
module tb_layer_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       clear_err = 1'b0;
    logic [7:0] num_layers = 8'd0;
    logic       load_start, input_compute_start, writeback_start;
    logic       load_done, input_compute_done, writeback_done;
    logic       busy, done, error;
    logic [7:0] layer_idx;
    logic [1:0] err_phase;

    logic ld_auto = 1'b0, cp_auto = 1'b0, wb_auto = 1'b0;
    logic ld_man = 1'b0;
    logic en_ld = 1'b1, en_cp = 1'b1, en_wb = 1'b1;
    int   ld_cnt = 0, cp_cnt = 0, wb_cnt = 0;

    assign load_done          = ld_auto | ld_man;
    assign input_compute_done = cp_auto;
    assign writeback_done     = wb_auto;

    int n_checks = 0;
    int n_fail   = 0;
    int ndone    = 0;
    int start_log[$];

    layer_scheduler #(
        .LAYER_W        (8),
        .TIMEOUT_W      (16),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .abort               (abort),
        .clear_err           (clear_err),
        .num_layers          (num_layers),
        .load_start          (load_start),
        .load_done           (load_done),
        .input_compute_start (input_compute_start),
        .input_compute_done  (input_compute_done),
        .writeback_start     (writeback_start),
        .writeback_done      (writeback_done),
        .busy                (busy),
        .layer_idx           (layer_idx),
        .done                (done),
        .error               (error),
        .err_phase           (err_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Engine models: answer 4 cycles after each start pulse; monitor logs starts
    always @(posedge clk) begin
        #1;
        ld_auto = 1'b0; cp_auto = 1'b0; wb_auto = 1'b0;
        if (ld_cnt != 0) begin ld_cnt--; if (ld_cnt == 0) ld_auto = 1'b1; end
        if (cp_cnt != 0) begin cp_cnt--; if (cp_cnt == 0) cp_auto = 1'b1; end
        if (wb_cnt != 0) begin wb_cnt--; if (wb_cnt == 0) wb_auto = 1'b1; end
        if (load_start && en_ld) ld_cnt = 4;
        if (input_compute_start && en_cp) cp_cnt = 4;
        if (writeback_start && en_wb) wb_cnt = 4;
        if (load_start)          start_log.push_back(32'h100 | int'(layer_idx));
        if (input_compute_start) start_log.push_back(32'h200 | int'(layer_idx));
        if (writeback_start)     start_log.push_back(32'h300 | int'(layer_idx));
        if (load_start || input_compute_start || writeback_start)
            check("start_onehot", 32'(load_start) + 32'(input_compute_start) + 32'(writeback_start), 1);
        if (done) ndone++;
    end

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 300) begin cyc(1); n++; end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

    initial begin
        int n, lsz, dsz;
        // Reset state
        cyc(2);
        check("rst_outputs", {load_start, input_compute_start, writeback_start, busy, done, error, err_phase}, 0);
        check("rst_layer_idx", layer_idx, 0);
        reset = 1'b1;
        cyc(2);
        check("idle_busy", busy, 0);

        // 1: three layers, all engines answer after 4 cycles
        start_log.delete();
        ndone = 0;
        num_layers = 8'd3; start = 1'b1;
        cyc(1);
        start = 1'b0;
        num_layers = 8'd7;
        check("t1_load_start_lat", load_start, 1);
        check("t1_busy", busy, 1);
        check("t1_idx0", layer_idx, 0);
        wait_done("t1", n);
        check("t1_cycles_to_done", n, 45);
        check("t1_busy_with_done", busy, 1);
        check("t1_idx_last", layer_idx, 2);
        cyc(1);
        check("t1_done_pulse", done, 0);
        check("t1_busy_fall", busy, 0);
        check("t1_num_starts", start_log.size(), 9);
        for (int i = 0; i < 9 && i < start_log.size(); i++)
            check($sformatf("t1_seq%0d", i), start_log[i], ((i % 3 + 1) << 8) | (i / 3));
        check("t1_done_count", ndone, 1);

        // 2: zero layers
        lsz = start_log.size();
        num_layers = 8'd0; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("t2_done", done, 1);
        check("t2_no_load", load_start, 0);
        cyc(1);
        check("t2_done_fall", done, 0);
        check("t2_busy_fall", busy, 0);
        cyc(3);
        check("t2_no_starts", start_log.size(), lsz);

        // 3: compute engine never answers, watchdog of 8
        en_cp = 1'b0;
        num_layers = 8'd2; start = 1'b1;
        cyc(1);
        start = 1'b0;
        n = 0;
        while (!input_compute_start && n < 50) begin cyc(1); n++; end
        check("t3_cp_issued", input_compute_start, 1);
        n = 0;
        while (!error && n < 50) begin cyc(1); n++; end
        check("t3_cycles_to_error", n, 9);
        check("t3_err_phase", err_phase, 2);
        check("t3_busy", busy, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("t3_start_ignored", error, 1);
        check("t3_no_load", load_start, 0);
        clear_err = 1'b1;
        cyc(1);
        clear_err = 1'b0;
        check("t3_cleared", error, 0);
        check("t3_err_phase_clr", err_phase, 0);
        check("t3_idle", busy, 0);
        en_cp = 1'b1;
        cyc(2);

        // 4: abort coinciding with writeback_done of layer 1 of 3
        dsz = ndone;
        num_layers = 8'd3; start = 1'b1;
        cyc(1);
        start = 1'b0;
        n = 0;
        while (!(writeback_done && layer_idx == 8'd1) && n < 200) begin cyc(1); n++; end
        check("t4_reached_wb1", writeback_done, 1);
        abort = 1'b1;
        cyc(1);
        abort = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_no_load", load_start, 0);
        lsz = start_log.size();
        cyc(20);
        check("t4_no_more_starts", start_log.size(), lsz);
        check("t4_no_done", ndone, dsz);
        num_layers = 8'd1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("t4_restart_load", load_start, 1);
        check("t4_restart_idx", layer_idx, 0);
        wait_done("t4", n);
        cyc(2);

        // 5: stray start and early load_done are ignored
        en_ld = 1'b0;
        num_layers = 8'd1; start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("t5_load_start", load_start, 1);
        ld_man = 1'b1;
        cyc(1);
        ld_man = 1'b0;
        check("t5_iss_done_ignored", input_compute_start, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        check("t5_start_ignored", load_start, 0);
        check("t5_busy", busy, 1);
        check("t5_still_wait", input_compute_start, 0);
        cyc(1);
        ld_man = 1'b1;
        cyc(1);
        ld_man = 1'b0;
        check("t5_cp_after_done", input_compute_start, 1);
        en_ld = 1'b1;
        wait_done("t5", n);
        cyc(2);

        // 6: asynchronous reset during CP_WAIT of layer 1
        num_layers = 8'd2; start = 1'b1;
        cyc(1);
        start = 1'b0;
        n = 0;
        while (!(input_compute_start && layer_idx == 8'd1) && n < 100) begin cyc(1); n++; end
        check("t6_cp_layer1", input_compute_start, 1);
        cyc(1);
        check("t6_busy_before", busy, 1);
        reset = 1'b0;
        #1;
        check("t6_async_outputs", {load_start, input_compute_start, writeback_start, busy, done, error, err_phase}, 0);
        check("t6_async_idx", layer_idx, 0);
        cyc(1);
        reset = 1'b1;
        cyc(6);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_idx", layer_idx, 0);
        check("t6_no_starts", {load_start, input_compute_start, writeback_start}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
